// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: NS/EW vehicle phases with all-red clearance,
// a latched pedestrian walk phase and a night flashing-yellow mode.
module traffic_light_ctrl #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int PED_TICKS    = 6,
  parameter int FLASH_TICKS  = 2,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  input  logic       flash,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_NS_G  = 3'd0,
    S_NS_Y  = 3'd1,
    S_AR1   = 3'd2,
    S_EW_G  = 3'd3,
    S_EW_Y  = 3'd4,
    S_AR2   = 3'd5,
    S_PED   = 3'd6,
    S_FLASH = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] G_LD   = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LD   = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_LD  = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] P_LD   = CNT_W'(PED_TICKS - 1);
  localparam logic [CNT_W-1:0] F_LD   = CNT_W'(FLASH_TICKS - 1);
  localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  // Lamp vector bit order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk}
  localparam logic [6:0] LAMPS_ALL_RED = 7'b0010010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_pend_q, ped_pend_d;
  logic             dir_q, dir_d;      // 1'b0: next green after a walk is NS, 1'b1: EW
  logic             blink_q, blink_d;
  logic [6:0]       lamps_q, lamps_d;

  function automatic logic [6:0] lamp_decode(input state_e s, input logic blink);
    logic [6:0] l;
    case (s)
      S_NS_G:  l = 7'b1000010;
      S_NS_Y:  l = 7'b0100010;
      S_EW_G:  l = 7'b0011000;
      S_EW_Y:  l = 7'b0010100;
      S_AR1:   l = LAMPS_ALL_RED;
      S_AR2:   l = LAMPS_ALL_RED;
      S_PED:   l = 7'b0010011;
      S_FLASH: l = {1'b0, blink, 1'b0, 1'b0, blink, 1'b0, 1'b0};
      default: l = LAMPS_ALL_RED;
    endcase
    return l;
  endfunction

  // Next-state, counter, walk latch and lamp decode of the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    dir_d   = dir_q;
    if (ped_req && (state_q != S_PED)) begin
      ped_pend_d = 1'b1;
    end else begin
      ped_pend_d = ped_pend_q;
    end

    if (en) begin
      if (state_q == S_FLASH) begin
        if (!flash) begin
          state_d = S_AR2;
          cnt_d   = AR_LD;
        end else if (cnt_q == C_ZERO) begin
          blink_d = ~blink_q;
          cnt_d   = F_LD;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end else if (cnt_q != C_ZERO) begin
        cnt_d = cnt_q - C_ONE;
      end else begin
        case (state_q)
          S_NS_G: begin state_d = S_NS_Y; cnt_d = Y_LD;  end
          S_NS_Y: begin state_d = S_AR1;  cnt_d = AR_LD; end
          S_EW_G: begin state_d = S_EW_Y; cnt_d = Y_LD;  end
          S_EW_Y: begin state_d = S_AR2;  cnt_d = AR_LD; end
          S_AR1, S_AR2: begin
            if (flash) begin
              state_d = S_FLASH;
              blink_d = 1'b1;
              cnt_d   = F_LD;
            end else if (ped_pend_q) begin
              // A request on the edge entering the walk is absorbed by it
              state_d    = S_PED;
              cnt_d      = P_LD;
              ped_pend_d = 1'b0;
              dir_d      = (state_q == S_AR1);
            end else begin
              state_d = (state_q == S_AR1) ? S_EW_G : S_NS_G;
              cnt_d   = G_LD;
            end
          end
          S_PED: begin
            state_d = dir_q ? S_EW_G : S_NS_G;
            cnt_d   = G_LD;
          end
          default: begin
            state_d = S_AR2;
            cnt_d   = AR_LD;
          end
        endcase
      end
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end

    lamps_d = lamp_decode(state_d, blink_d);
  end

  // State, counter and registered lamp outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_AR2;
      cnt_q      <= AR_LD;
      ped_pend_q <= 1'b0;
      dir_q      <= 1'b0;
      blink_q    <= 1'b0;
      lamps_q    <= LAMPS_ALL_RED;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_pend_q <= ped_pend_d;
      dir_q      <= dir_d;
      blink_q    <= blink_d;
      lamps_q    <= lamps_d;
    end
  end

  assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk} = lamps_q;
  assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed, table-driven bench for traffic_light_ctrl with default parameters;
// expected phases and lamp patterns are hand-derived constants.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, ped_req, flash;
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk;
  logic [2:0] phase;
  logic [6:0] lamps;

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk}
  localparam logic [6:0] L_NSG  = 7'b1000010;
  localparam logic [6:0] L_NSY  = 7'b0100010;
  localparam logic [6:0] L_AR   = 7'b0010010;
  localparam logic [6:0] L_EWG  = 7'b0011000;
  localparam logic [6:0] L_EWY  = 7'b0010100;
  localparam logic [6:0] L_PED  = 7'b0010011;
  localparam logic [6:0] L_FON  = 7'b0100100;
  localparam logic [6:0] L_FOFF = 7'b0000000;

  traffic_light_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req), .flash(flash),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .ped_walk(ped_walk), .phase(phase)
  );

  always #5 clk = ~clk;

  assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk};

  typedef struct {
    logic       rst;
    logic       en;
    logic       ped;
    logic       flash;
    int         reps;
    logic [2:0] ph;
    logic [6:0] lamps;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input int n, input logic [2:0] ph, input logic [6:0] l,
                     input logic p = 1'b0, input logic f = 1'b0,
                     input logic e = 1'b1, input logic r = 1'b0);
    vec_t v;
    v.rst = r; v.en = e; v.ped = p; v.flash = f;
    v.reps = n; v.ph = ph; v.lamps = l;
    vecs.push_back(v);
  endtask

  task automatic add_rst();
    add(1, 3'd5, L_AR, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic step(input logic r, input logic e, input logic p, input logic f);
    rst = r; en = e; ped_req = p; flash = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [2:0] eph, input logic [6:0] el);
    n_tests++;
    if ((phase !== eph) || (lamps !== el)) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d lamps=%b, want phase=%0d lamps=%b",
               nm, phase, lamps, eph, el);
    end
  endtask

  logic [2:0] exp_ph[$];
  logic [6:0] exp_l[$];
  int         seg_len[7] = '{2, 8, 3, 2, 8, 3, 2};
  logic [2:0] seg_ph[7]  = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [6:0] seg_l[7]   = '{L_AR, L_NSG, L_NSY, L_AR, L_EWG, L_EWY, L_AR};

  initial begin
    rst = 1'b1; en = 1'b0; ped_req = 1'b0; flash = 1'b0;

    // Free-running cycle from reset
    add_rst();
    add(1, 3'd5, L_AR); add(8, 3'd0, L_NSG); add(3, 3'd1, L_NSY); add(2, 3'd2, L_AR);
    add(8, 3'd3, L_EWG); add(3, 3'd4, L_EWY); add(2, 3'd5, L_AR); add(8, 3'd0, L_NSG);
    add(1, 3'd1, L_NSY);
    // Reset with en=0 mid NS_Y, then one walk; requests inside/entering PED ignored
    add(1, 3'd5, L_AR, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1, 3'd5, L_AR); add(3, 3'd0, L_NSG); add(1, 3'd0, L_NSG, 1'b1); add(4, 3'd0, L_NSG);
    add(3, 3'd1, L_NSY); add(2, 3'd2, L_AR);
    add(1, 3'd6, L_PED, 1'b1); add(2, 3'd6, L_PED); add(1, 3'd6, L_PED, 1'b1); add(2, 3'd6, L_PED);
    add(8, 3'd3, L_EWG); add(3, 3'd4, L_EWY); add(2, 3'd5, L_AR); add(8, 3'd0, L_NSG);
    add(3, 3'd1, L_NSY); add(2, 3'd2, L_AR); add(2, 3'd3, L_EWG);
    add(2, 3'd3, L_EWG, 1'b0, 1'b0, 1'b0); add(1, 3'd3, L_EWG);
    // Request on the AR1 exit edge is latched but only served after AR2
    add_rst();
    add(1, 3'd5, L_AR); add(8, 3'd0, L_NSG); add(3, 3'd1, L_NSY); add(2, 3'd2, L_AR);
    add(1, 3'd3, L_EWG, 1'b1); add(7, 3'd3, L_EWG); add(3, 3'd4, L_EWY); add(2, 3'd5, L_AR);
    add(6, 3'd6, L_PED); add(8, 3'd0, L_NSG); add(1, 3'd1, L_NSY);
    // Flash raised mid EW_G: phases complete, then blink 1,1,0,0,1,1,0; drop -> AR2 -> NS_G
    add_rst();
    add(1, 3'd5, L_AR); add(8, 3'd0, L_NSG); add(3, 3'd1, L_NSY); add(2, 3'd2, L_AR);
    add(3, 3'd3, L_EWG); add(5, 3'd3, L_EWG, 1'b0, 1'b1); add(3, 3'd4, L_EWY, 1'b0, 1'b1);
    add(2, 3'd5, L_AR, 1'b0, 1'b1);
    add(2, 3'd7, L_FON, 1'b0, 1'b1); add(2, 3'd7, L_FOFF, 1'b0, 1'b1);
    add(2, 3'd7, L_FON, 1'b0, 1'b1); add(1, 3'd7, L_FOFF, 1'b0, 1'b1);
    add(2, 3'd5, L_AR); add(2, 3'd0, L_NSG);
    // Walk and flash both pending at AR1 end: FLASH first, then AR2, PED, NS_G
    add_rst();
    add(1, 3'd5, L_AR); add(2, 3'd0, L_NSG); add(1, 3'd0, L_NSG, 1'b1); add(5, 3'd0, L_NSG);
    add(3, 3'd1, L_NSY); add(2, 3'd2, L_AR, 1'b0, 1'b1);
    add(2, 3'd7, L_FON, 1'b0, 1'b1); add(1, 3'd7, L_FOFF, 1'b0, 1'b1);
    add(2, 3'd5, L_AR); add(6, 3'd6, L_PED); add(8, 3'd0, L_NSG); add(1, 3'd1, L_NSY);
    // Reset during PED (request and flash asserted on the reset edge)
    add_rst();
    add(1, 3'd5, L_AR); add(1, 3'd0, L_NSG, 1'b1); add(7, 3'd0, L_NSG); add(3, 3'd1, L_NSY);
    add(2, 3'd2, L_AR); add(3, 3'd6, L_PED);
    add(1, 3'd5, L_AR, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1, 3'd5, L_AR); add(8, 3'd0, L_NSG); add(3, 3'd1, L_NSY); add(2, 3'd2, L_AR);
    add(8, 3'd3, L_EWG); add(3, 3'd4, L_EWY); add(2, 3'd5, L_AR); add(1, 3'd0, L_NSG);
    // Reset during FLASH with a walk pending: the walk is dropped
    add_rst();
    add(1, 3'd5, L_AR); add(1, 3'd0, L_NSG, 1'b1); add(7, 3'd0, L_NSG); add(3, 3'd1, L_NSY);
    add(2, 3'd2, L_AR, 1'b0, 1'b1);
    add(2, 3'd7, L_FON, 1'b0, 1'b1); add(1, 3'd7, L_FOFF, 1'b0, 1'b1);
    add(1, 3'd5, L_AR, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1, 3'd5, L_AR); add(8, 3'd0, L_NSG); add(3, 3'd1, L_NSY); add(2, 3'd2, L_AR);
    add(8, 3'd3, L_EWG); add(3, 3'd4, L_EWY); add(2, 3'd5, L_AR); add(1, 3'd0, L_NSG);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        step(vecs[i].rst, vecs[i].en, vecs[i].ped, vecs[i].flash);
        check($sformatf("vec%0d.%0d", i, r), vecs[i].ph, vecs[i].lamps);
      end
    end

    // en high on one edge in three: each enabled tick spans three clocks
    for (int s = 0; s < 7; s++) begin
      for (int k = 0; k < seg_len[s]; k++) begin
        exp_ph.push_back(seg_ph[s]);
        exp_l.push_back(seg_l[s]);
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("en3_reset", 3'd5, L_AR);
    for (int i = 0; i < 78; i++) begin
      step(1'b0, (i % 3) == 2, 1'b0, 1'b0);
      check($sformatf("en3_edge%0d", i), exp_ph[(i + 1) / 3], exp_l[(i + 1) / 3]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-way (NS/EW) intersection controller with programmable phase durations, tick-enable pacing, a latched pedestrian-walk phase and a night flashing-yellow mode. It replaces the fixed-timing controller at the top of the traffic design. Output lamps are a pure decode of a registered state, so they are glitch-free.

## Interface
- GREEN_TICKS, 8: green duration per direction, in enabled ticks (≥1)
- YELLOW_TICKS, 3: yellow duration per direction (≥1)
- ALLRED_TICKS, 2: all-red clearance after each yellow (≥1)
- PED_TICKS, 6: pedestrian walk duration (≥1)
- FLASH_TICKS, 2: half-period of flashing yellow (≥1)
- CNT_W, 8: phase counter width; must hold max(all *_TICKS)−1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  tick enable; phase counter and state advance only on edges with en=1
- ped_req  in  1  pedestrian request, sampled every clk edge
- flash  in  1  night-mode request, level
- ns_g, ns_y, ns_r  out  1 each  north-south lamps
- ew_g, ew_y, ew_r  out  1 each  east-west lamps
- ped_walk  out  1  walk signal
- phase  out  3  current state encoding (debug)

## Operation
- States (phase code): NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, PED=6, FLASH=7.
- Lamp decode: NS_G→ns_g, ew_r. NS_Y→ns_y, ew_r. EW_G→ew_g, ns_r. EW_Y→ew_y, ns_r. AR1/AR2/PED→ns_r, ew_r. PED also drives ped_walk=1. FLASH→ns_y=ew_y=blink, all reds and greens 0.
- Counter: entering a state loads cnt = duration−1. Each en=1 edge with cnt≠0 decrements cnt. An en=1 edge with cnt=0 takes the transition. Every state therefore lasts exactly its duration in enabled ticks. en=0 freezes the state and counter.
- Normal sequence: NS_G→NS_Y→AR1→EW_G→EW_Y→AR2→NS_G.
- Exit from AR1/AR2 (cnt=0, en=1), in priority order:
  - flash=1 → FLASH, with blink=1 and cnt=FLASH_TICKS−1.
  - else ped_pend=1 → PED, clearing ped_pend. The next green is EW_G after AR1 and NS_G after AR2, held in a dir register.
  - else the normal next green.
- PED exits to the green selected by dir.
- ped_pend: set on any clk edge with ped_req=1 while the state is not PED, regardless of en. Requests during PED are ignored. Multiple requests collapse into one walk.
- flash is only acted on at the end of an all-red phase. Green and yellow phases always complete.
- FLASH: on each en=1 edge with cnt=0, blink toggles and cnt reloads FLASH_TICKS−1. An en=1 edge with flash=0 exits to AR2 with cnt=ALLRED_TICKS−1 (blink irrelevant). ped_pend is retained across FLASH.
- Safety invariant: no cycle has any NS lamp green or yellow while any EW lamp is green or yellow, except the FLASH yellows.

## Timing
- Reset (rst=1 at an edge): state=AR2, cnt=ALLRED_TICKS−1, ped_pend=0, dir=NS, blink=0.
- Reset outputs: ns_r=ew_r=1, all other lamps 0, ped_walk=0, phase=5. rst overrides en and all other inputs, mid-phase included.
- Outputs change on the same edge as the state: zero combinational input→output paths.
- With en held at 1 and default parameters:
  - NS_G is entered on the ALLRED_TICKS-th edge after rst falls.
  - The vehicle cycle period is 2·(G+Y+AR) = 26 clocks. A walk adds PED_TICKS = 6.
- ped_req asserted on the same edge that enters PED is not latched. ped_req asserted on the AR exit edge is latched, but it is too late for that exit.

## Test plan
- Reset, then en=1, no requests → phases 5,5 (2 clk), 0×8, 1×3, 2×2, 3×8, 4×3, 5×2, repeating with a 26-clock period; exactly one lamp per direction lit every cycle.
- en toggled 1-of-3 cycles → every phase lasts 3× its clock count; state and lamps never change on en=0 edges.
- One-cycle ped_req during NS_G → after NS_Y and AR1: ped_walk=1 with both reds for 6 clocks, then EW_G. A second ped_req inside PED yields no further walk.
- flash=1 raised mid EW_G → EW_G, EW_Y and AR2 complete, then FLASH with ns_y=ew_y toggling every 2 clocks (1,1,0,0,…). Dropping flash → AR2 for 2 clocks, then NS_G.
- ped_req and flash both pending at the end of AR1 → FLASH is taken first. After flash drops: AR2, then PED (6), then NS_G.
- rst pulsed during PED and during FLASH → next edge: phase=5, ns_r=ew_r=1, ped_walk=0, yellows 0, pending request cleared (no walk follows).
